// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, default width and
// the counter-width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DEFAULT_WIDTH = 4;

    // $clog2(1) is 0, so keep at least one counter bit for degenerate widths.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/addsub_unit.sv
// Ripple-carry adder/subtractor; sub=1 inverts b and injects a carry-in of 1,
// so carry_out is the inverted borrow when subtracting.
module addsub_unit #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] result,
    output logic         carry_out
);

    logic [W:0]   carry;
    logic [W-1:0] b_eff;

    assign carry[0] = sub;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign b_eff[gi]    = b[gi] ^ sub;
        assign result[gi]   = a[gi] ^ b_eff[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
    end

    assign carry_out = carry[W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per clock
// through a single shared WIDTH+1 bit subtractor.
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_r_q, q_r_d;
    logic [WIDTH-1:0] d_r_q, d_r_d;
    logic [WIDTH:0]   p_r_q, p_r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             carry_out;
    logic             borrow;

    // P_r never exceeds D_r, so its top bit is always zero and drops out here.
    assign trial = (WIDTH+1)'({p_r_q, q_r_q[WIDTH-1]});

    addsub_unit #(
        .W(WIDTH + 1)
    ) u_sub (
        .a        (trial),
        .b        ({1'b0, d_r_q}),
        .sub      (1'b1),
        .result   (diff),
        .carry_out(carry_out)
    );

    assign borrow = ~carry_out;

    always_comb begin
        state_d     = state_q;
        q_r_d       = q_r_q;
        d_r_d       = d_r_q;
        p_r_d       = p_r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_r_d = dividend;
                    d_r_d = divisor;
                    p_r_d = '0;
                    cnt_d = CW'(WIDTH - 1);
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                q_r_d = WIDTH'({q_r_q, ~borrow});
                p_r_d = borrow ? trial : diff;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = q_r_d;
                    remainder_d = p_r_d[WIDTH-1:0];
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_r_q       <= '0;
            d_r_q       <= '0;
            p_r_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_r_q       <= q_r_d;
            d_r_q       <= d_r_d;
            p_r_q       <= p_r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against a plain-arithmetic
// reference model of quotient, remainder, latency and divide-by-zero results.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec  = 0;
    int n_miss = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? (1 << W) - 1 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input int b);
        return (b == 0) ? 1 : W + 1;
    endfunction

    // One isolated operation: start for one cycle, then watch busy/done.
    task automatic do_op(input int a, input int b);
        int  k;
        int  lat;
        int  nbusy;
        bit  seen;
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        seen  = 1'b0;
        nbusy = 0;
        lat   = 0;
        k     = 1;
        while (!seen && k <= 16) begin
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check("done_seen", int'(seen), 1);
        check("latency", lat, ref_lat(b));
        check("busy_cycles", nbusy, ref_lat(b));
        check("quotient", int'(quotient), ref_q(a, b));
        check("remainder", int'(remainder), ref_r(a, b));
        check("div_by_zero", int'(div_by_zero), (b == 0) ? 1 : 0);
        $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient, remainder,
                 div_by_zero, lat);
        @(negedge clk);
        check("done_single", int'(done), 0);
        check("busy_after", int'(busy), 0);
        check("q_hold", int'(quotient), ref_q(a, b));
    endtask

    initial begin
        int ndone;
        int cap_q;
        int cap_r;
        int pairs[256];
        int exp_q[$];
        int idx;
        int last_done;
        int cyc;
        int got;
        int ea;
        int eb;
        int j;
        int tmp;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_op(13, 3);
        do_op(15, 1);
        do_op(2, 9);
        do_op(0, 5);
        do_op(15, 15);
        do_op(7, 0);
        do_op(9, 2);
        for (int i = 0; i < 6; i++) do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

        // Second request during ITER must be dropped.
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; cap_q = -1; cap_r = -1;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                cap_q = int'(quotient);
                cap_r = int'(remainder);
            end
            @(negedge clk);
        end
        check("ignore_ndone", ndone, 1);
        check("ignore_q", cap_q, 12 / 5);
        check("ignore_r", cap_r, 12 % 5);
        $display("op 12/5 with ignored 1/1 -> q=%0d r=%0d pulses=%0d", cap_q, cap_r, ndone);

        // Asynchronous reset two steps into 14/3.
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_q", int'(quotient), 0);
        check("abort_r", int'(remainder), 0);
        check("abort_dbz", int'(div_by_zero), 0);
        ndone = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        rst_n = 1'b1;
        $display("op 14/3 aborted by reset, pulses=%0d", ndone);
        do_op(14, 3);

        // All 256 pairs in shuffled order, start held high throughout.
        for (int i = 0; i < 256; i++) pairs[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
        end
        @(negedge clk);
        idx = 0;
        last_done = -1;
        cyc = 0;
        got = 0;
        start = 1'b1;
        while (got < 256 && cyc < 256 * 8 + 50) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious_done", 1, 0);
                end else begin
                    tmp = exp_q.pop_front();
                    ea = tmp / 16;
                    eb = tmp % 16;
                    check("stream_q", int'(quotient), ref_q(ea, eb));
                    check("stream_r", int'(remainder), ref_r(ea, eb));
                    check("stream_dbz", int'(div_by_zero), (eb == 0) ? 1 : 0);
                    if (last_done >= 0) check("stream_period", cyc - last_done, ref_lat(eb) + 1);
                    $display("stream %0d/%0d -> q=%0d r=%0d dbz=%0d", ea, eb, quotient,
                             remainder, div_by_zero);
                end
                last_done = cyc;
                got++;
            end
            if (!busy && idx < 256) begin
                dividend = W'(pairs[idx] / 16);
                divisor  = W'(pairs[idx] % 16);
                exp_q.push_back(pairs[idx]);
                idx++;
            end else if (!busy) begin
                start = 1'b0;
            end else begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("stream_count", got, 256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider built on the team's ripple add/subtract datapath. It accepts a WIDTH-bit dividend and divisor on a start pulse and runs one shift-and-subtract step per clock through a single shared subtractor. It returns the quotient and remainder with a one-cycle done pulse. It sits beside the combinational adder/subtractor in the arithmetic unit and gives the design division without a second array.

## Interface
- WIDTH, 4, operand/result width in bits; iteration count equals WIDTH
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend; sampled with start
- divisor  input  WIDTH  unsigned divisor; sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse
- quotient  output  WIDTH  registered result
- remainder  output  WIDTH  registered result
- div_by_zero  output  1  registered; set with done when the divisor was 0

## Operation
- States:
  - IDLE
  - ITER (WIDTH steps)
  - DONE (1 cycle, done=1)
- IDLE, start=1:
  - Latch the dividend into shift register Q_r and the divisor into D_r.
  - Clear the partial remainder P_r (WIDTH+1 bits).
  - Load the step counter with WIDTH-1.
  - Go to ITER, or go to DONE directly if divisor==0.
- ITER step:
  - Form T = {P_r[WIDTH-1:0], Q_r[WIDTH-1]}, which is WIDTH+1 bits.
  - Compute S = T - {1'b0, D_r} on the shared subtractor and take the borrow-out B.
  - B=0: P_r <= S, and shift Q_r left with a 1 in the LSB.
  - B=1: P_r <= T, and shift Q_r left with a 0 in the LSB.
  - Counter decrements each step; the step taken with counter==0 moves to DONE.
- DONE entry, normal path: quotient <= Q_r, remainder <= P_r[WIDTH-1:0], div_by_zero <= 0.
- DONE entry, divide by zero: quotient <= all ones, remainder <= dividend, div_by_zero <= 1.
- DONE always returns to IDLE on the next edge.
- Result registers change only on DONE entry; they hold until the next operation completes.
- start while busy (ITER or DONE) is ignored, with no queuing.
  - start held high through DONE is re-sampled in the following IDLE cycle.
- Arithmetic:
  - All unsigned.
  - P_r never exceeds D_r after any step, so WIDTH+1 bits cannot overflow.
  - The subtractor is two's complement: invert the subtrahend and carry-in 1. Borrow = NOT carry-out.

## Timing
- Reset: asynchronous; takes effect immediately on rst_n low.
  - state=IDLE.
  - busy, done, div_by_zero = 0.
  - quotient, remainder, Q_r, D_r, P_r, counter = 0.
- Reset mid-operation aborts the operation with no done pulse; outputs return to 0.
- Edge E0 samples start.
- Normal latency:
  - Steps occur at E1..EWIDTH.
  - done is high in the cycle after edge EWIDTH, i.e. after edge E4 when WIDTH=4.
  - busy is high from after E0 through the DONE cycle inclusive.
- Divide-by-zero latency: done is high in the cycle after E0, and busy is high for that one cycle.
- Back-to-back: the earliest next accept is the edge ending the first IDLE cycle after DONE.
  - Minimum period is WIDTH+2 cycles.
- done is never high for more than one consecutive cycle.

## Structure
- Shared package arith_pkg:
  - state enum (IDLE, ITER, DONE)
  - DEFAULT_WIDTH = 4
  - counter width as $clog2(WIDTH)
- One sub-module: addsub_unit.
  - Parameterized width; ports a, b, sub, result, carry_out.
  - Instantiated once at WIDTH+1 with sub tied 1.
  - The same unit is reused by the adder/subtractor path.
- The FSM, counter and shift registers live in seq_divider; there is no other hierarchy.

## Test plan
- Reset, then 13/3 (start one cycle):
  - done 5 cycles after start is asserted (after edge E4).
  - quotient=4, remainder=1, div_by_zero=0.
  - busy high for exactly 5 cycles.
- Edge values:
  - 15/1 → Q=15, R=0.
  - 2/9 → Q=0, R=2.
  - 0/5 → Q=0, R=0.
  - 15/15 → Q=1, R=0.
- 7/0:
  - done in the cycle after E0.
  - Q=4'hF, R=7, div_by_zero=1, busy high for 1 cycle.
  - The next op, 9/2, gives Q=4, R=1 and div_by_zero cleared.
- Start 12/5, then pulse start with 1/1 during ITER:
  - The second request is ignored; the result is Q=2, R=2.
  - Exactly one done pulse.
- Deassert rst_n at step 2 of 14/3:
  - All outputs go to 0 immediately, with no done pulse.
  - After release, 14/3 completes with Q=4, R=2.
- Exhaustive random: all 256 operand pairs back-to-back, with start held high continuously.
  - Each result matches a/b and a%b.
  - Results arrive every 6 cycles.
  - Divisor 0 cases follow the divide-by-zero rule.
